// File: rtl/power_calc.sv
// ---------------------------------------------------------------------------
// power_calc
//
// Fixed-point integer-power engine. Raises an unsigned Q10.10 base to a small
// integer exponent (0..5, larger codes clamp to 5) by iterated multiplication,
// one multiply per clock, and returns an unsigned Q50.10 result.
//
// Ports:
//   clk        in   1       clock
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       request strobe, sampled only while idle
//   in_data_1  in   BASE_W  base, unsigned Q10.10
//   in_data_2  in   3       exponent n (6 and 7 are treated as 5)
//   busy       out  1       high from the accepting edge until back in IDLE
//   out_valid  out  1       one-cycle result strobe
//   out_data   out  OUT_W   result, unsigned Q50.10; zero when out_valid is low
//
// Build option:
//   POWER_CALC_ROUND_EN  when defined, every multiply step rounds half-up
//                        instead of truncating toward zero.
// ---------------------------------------------------------------------------
module power_calc #(
    parameter int FRAC_W  = 10,
    parameter int BASE_W  = 20,
    parameter int OUT_W   = 60,
    parameter int MAX_EXP = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BASE_W-1:0] in_data_1,
    input  logic [2:0]        in_data_2,
    output logic              busy,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data
);

    localparam int PROD_W = OUT_W + BASE_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [BASE_W-1:0]   r_base;
    logic [OUT_W-1:0]    r_acc;
    logic [2:0]          r_cnt;
    logic                r_busy;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_data;

    logic [2:0]          w_exp_clamped;
    logic [OUT_W-1:0]    w_acc_next;

    // One accumulate step: full-width product, optional half-ulp bias, then
    // drop the fractional bits. The product can never exceed OUT_W integer
    // range for legal bases, so narrowing the shifted value loses nothing.
    function automatic logic [OUT_W-1:0] mul_step(
        input logic [OUT_W-1:0]  acc,
        input logic [BASE_W-1:0] base
    );
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(acc) * PROD_W'(base);
`ifdef POWER_CALC_ROUND_EN
        prod = prod + (PROD_W'(1) << (FRAC_W - 1));
`endif
        mul_step = OUT_W'(prod >> FRAC_W);
    endfunction

    assign w_exp_clamped = (in_data_2 > 3'(MAX_EXP)) ? 3'(MAX_EXP) : in_data_2;
    assign w_acc_next    = mul_step(r_acc, r_base);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == 3'd0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_base <= in_data_1;
                        r_cnt  <= w_exp_clamped;
                        r_acc  <= OUT_W'(1) << FRAC_W;
                        r_busy <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (r_cnt != 3'd0) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_out_data  <= r_acc;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_power_calc.sv
module tb_power_calc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_data_1;
    logic [2:0]  in_data_2;
    logic        busy;
    logic        out_valid;
    logic [59:0] out_data;

    int checks;
    int errors;

`ifdef POWER_CALC_ROUND_EN
    localparam logic [59:0] EXP_555 = 60'h71C;
`else
    localparam logic [59:0] EXP_555 = 60'h71B;
`endif

    power_calc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for exactly one sampling edge.
    task automatic start_req(input logic [19:0] base, input logic [2:0] n);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data_1 = base;
        in_data_2 = n;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data_1 = 20'hABCDE;
        in_data_2 = 3'd6;
    endtask

    // Observe 20 cycles following the accepting edge (k = 0 is the cycle
    // right after it). Reports first result, its cycle, busy cycles, number
    // of strobes and cycles where out_data was nonzero without out_valid.
    task automatic capture(output logic [59:0] val, output int lat,
                           output int busy_n, output int pulses,
                           output int zero_viol);
        val = '0; lat = -1; busy_n = 0; pulses = 0; zero_viol = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (out_valid) begin
                if (pulses == 0) begin
                    val = out_data;
                    lat = k;
                end
                pulses++;
            end else if (out_data !== '0) begin
                zero_viol++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data_1 = '0;
        in_data_2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (out_data !== 60'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [59:0] v; int lat, bn, p, zv;
        start_req(20'h00800, 3'd3);
        capture(v, lat, bn, p, zv);
        checks++;
        if (v !== 60'h2000) begin errors++; $display("FAIL basic_value got %h exp 2000", v); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
        checks++;
        if (bn !== 5) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 5", bn); end
        checks++;
        if (p !== 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", p); end
        checks++;
        if (zv !== 0) begin errors++; $display("FAIL basic_data_zero_when_invalid got %0d exp 0", zv); end
    endtask

    task automatic test_powers();
        logic [19:0] bases [8];
        logic [2:0]  exps  [8];
        logic [59:0] expv  [8];
        int          expl  [8];
        logic [59:0] v; int lat, bn, p, zv;
        bases = '{20'hFFC00, 20'h00600, 20'h12345, 20'h00000,
                  20'h00800, 20'h00555, 20'h00400, 20'h00000};
        exps  = '{3'd2, 3'd2, 3'd0, 3'd4, 3'd7, 3'd2, 3'd5, 3'd0};
        expv  = '{60'h3FE00400, 60'h900, 60'h400, 60'h0,
                  60'h8000, EXP_555, 60'h400, 60'h400};
        expl  = '{3, 3, 1, 5, 6, 3, 6, 1};
        for (int i = 0; i < 8; i++) begin
            start_req(bases[i], exps[i]);
            capture(v, lat, bn, p, zv);
            checks++;
            if (v !== expv[i]) begin
                errors++;
                $display("FAIL pow_value[%0d] base %h n %0d got %h exp %h", i, bases[i], exps[i], v, expv[i]);
            end
            checks++;
            if (lat !== expl[i]) begin
                errors++;
                $display("FAIL pow_latency[%0d] got %0d exp %0d", i, lat, expl[i]);
            end
            checks++;
            if (p !== 1 || bn !== expl[i] + 1 || zv !== 0) begin
                errors++;
                $display("FAIL pow_handshake[%0d] pulses %0d busy %0d zero_viol %0d exp 1 %0d 0", i, p, bn, zv, expl[i] + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [59:0] v; int lat, bn, p, zv; int seen;
        // Second strobe while busy must be ignored.
        start_req(20'h00800, 3'd3);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data_1 = 20'hFFC00;
        in_data_2 = 3'd2;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        capture(v, lat, bn, p, zv);
        checks++;
        if (v !== 60'h2000) begin errors++; $display("FAIL b2b_ignored_value got %h exp 2000", v); end
        checks++;
        if (p !== 1 || lat !== 3) begin
            errors++;
            $display("FAIL b2b_ignored_pulses got %0d at %0d exp 1 at 3", p, lat);
        end
        // Request in the IDLE cycle right after DONE must be accepted.
        start_req(20'h00800, 3'd1);
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen !== 1) begin errors++; $display("FAIL b2b_first_done got %0d exp 1", seen); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
        in_valid  = 1'b1;
        in_data_1 = 20'h00600;
        in_data_2 = 3'd2;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        capture(v, lat, bn, p, zv);
        checks++;
        if (v !== 60'h900 || lat !== 3) begin
            errors++;
            $display("FAIL b2b_after_done got %h at %0d exp 900 at 3", v, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [59:0] v; int lat, bn, p, zv;
        start_req(20'h00800, 3'd5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 60'h0) begin
            errors++;
            $display("FAIL abort_state busy %b valid %b data %h exp 0 0 0", busy, out_valid, out_data);
        end
        capture(v, lat, bn, p, zv);
        checks++;
        if (p !== 0 || bn !== 0) begin
            errors++;
            $display("FAIL abort_no_result pulses %0d busy %0d exp 0 0", p, bn);
        end
        start_req(20'h00600, 3'd2);
        capture(v, lat, bn, p, zv);
        checks++;
        if (v !== 60'h900 || p !== 1) begin
            errors++;
            $display("FAIL abort_recover got %h pulses %0d exp 900 1", v, p);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_powers();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
